// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// One transaction outstanding; data has priority, bounded by a fetch starvation counter.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state, stateNext;
    logic        ownerI;
    logic        dropFlag;
    logic [3:0]  starveCnt;
    logic        latWe;
    logic [3:0]  latBe;
    logic [31:0] latAddr, latWdata;
    logic [31:0] iRdataReg, dRdataReg;
    logic        anyReq, fetchWins;

    always_comb begin
        anyReq    = i_req | d_req;
        fetchWins = i_req & (~d_req | (starveCnt == LIMIT));
    end

    always_comb begin
        stateNext = state;
        m_req     = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state)
            IDLE:  if (anyReq) stateNext = ISSUE;
            ISSUE: begin
                m_req = 1'b1;
                if (m_gnt) stateNext = WAIT;
            end
            WAIT:  if (m_rvalid) stateNext = RESP;
            RESP:  begin
                // A flush arriving in the response cycle itself also discards the fetch.
                i_ack     = ownerI & ~dropFlag & ~i_flush;
                d_ack     = ~ownerI;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ownerI    <= 1'b0;
            dropFlag  <= 1'b0;
            starveCnt <= '0;
            latWe     <= 1'b0;
            latBe     <= '0;
            latAddr   <= '0;
            latWdata  <= '0;
            iRdataReg <= '0;
            dRdataReg <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (!i_req) starveCnt <= '0;
                    if (anyReq) begin
                        ownerI <= fetchWins;
                        if (fetchWins) begin
                            latWe     <= 1'b0;
                            latBe     <= '1;
                            latAddr   <= i_addr;
                            latWdata  <= '0;
                            starveCnt <= '0;
                        end else begin
                            latWe    <= d_we;
                            latBe    <= d_be;
                            latAddr  <= d_addr;
                            latWdata <= d_wdata;
                            if (i_req && starveCnt != LIMIT) starveCnt <= starveCnt + 4'd1;
                        end
                    end
                end
                ISSUE, WAIT: if (ownerI && i_flush) dropFlag <= 1'b1;
                RESP: dropFlag <= 1'b0;
                default: ;
            endcase
            if (state == WAIT && m_rvalid) begin
                if (ownerI) iRdataReg <= m_rdata;
                else        dRdataReg <= m_rdata;
            end
        end
    end

    assign m_we    = latWe;
    assign m_be    = latBe;
    assign m_addr  = latAddr;
    assign m_wdata = latWdata;
    assign i_rdata = iRdataReg;
    assign d_rdata = dRdataReg;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port external memory between the pipeline's instruction-fetch requester and its data (load/store) requester.
- Sits between the core's fetch/memory stages and the memory bus.
- Serialises transactions, one outstanding at a time, with a data-priority policy and an anti-starvation counter for fetch.
- Supports fetch abort on a taken branch/jump.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while i_req pends before fetch is forced to win (legal range 1..15).

Ports:
- clk  in  1  clock; all flops rising-edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held stable with i_addr until i_ack.
- i_addr  in  32  fetch word address.
- i_flush  in  1  discard the fetch in flight (branch/jump redirect).
- i_ack  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held stable with d_we/d_be/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse: load data valid or store complete.
- d_rdata  out  32  load data (raw word).
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_be  out  4  memory byte enables.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_gnt  in  1  memory accepts the request this cycle.
- m_rvalid  in  1  memory response (reads and writes).
- m_rdata  in  32  memory read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is pending, arbitrate.
  - Latch the winner's fields into internal regs and set owner (I or D).
  - Go to ISSUE on the next edge.
  - With no request, stay in IDLE.
- Arbitration:
  - d_req wins unless i_req && starve_cnt == STARVE_LIMIT, in which case i_req wins.
  - starve_cnt increments on each data grant while i_req is high, saturating at STARVE_LIMIT.
  - starve_cnt clears on any fetch grant or whenever i_req is low in IDLE.
- ISSUE:
  - m_req = 1; m_we/m_be/m_addr/m_wdata come from the latched regs.
  - For a fetch, m_we = 0 and m_be = 4'hF.
  - Fields are stable until m_gnt. On m_gnt go to WAIT.
- WAIT:
  - m_req = 0.
  - On m_rvalid, capture m_rdata into the owner's rdata reg and go to RESP.
  - m_rvalid is ignored in every state except WAIT.
- RESP:
  - Owner's ack = 1 for exactly one cycle, then IDLE.
  - The requester updates or drops req on the edge where it sees ack, so IDLE never re-grants a completed request.
- Latency: minimum 3 cycles from req seen in IDLE to ack (IDLE→ISSUE, m_gnt same cycle→WAIT, m_rvalid→RESP ack). Each cycle of m_gnt or m_rvalid delay adds one.
- Flush:
  - If i_flush is asserted in any cycle while owner = I and state is ISSUE, WAIT or RESP, set the drop flag.
  - The transaction still completes on the bus; no request is withdrawn after issue.
  - i_ack is suppressed in RESP.
  - The drop flag clears on return to IDLE.
  - i_flush in IDLE has no effect.
  - i_flush never affects a data transaction.
- Simultaneous i_req and d_req in IDLE: only one grant; the loser stays pending.
- i_rdata and d_rdata hold their last captured value until the next capture for the same owner.
- Reset (async, any state, mid-transaction included):
  - State returns to IDLE; starve_cnt, drop flag and owner are cleared.
  - m_req, m_we, i_ack, d_ack = 0; m_be = 0.
  - m_addr, m_wdata, i_rdata, d_rdata = 0.
  - A late m_rvalid after reset is ignored (IDLE).

Test Plan:
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x0000_0100, m_gnt tied 1, m_rvalid one cycle after gnt with m_rdata=0x0000_0013.
  - Required: m_req high exactly 1 cycle with m_addr=0x100, m_be=F, m_we=0; i_ack pulses in cycle 3 with i_rdata=0x13; d_ack stays 0.
- Store:
  - Stimulus: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xDEAD_BEEF; m_gnt delayed 2 cycles.
  - Required: m_req held 3 cycles with stable fields; d_ack one-cycle pulse after m_rvalid; total latency 5 cycles.
- Priority and starvation:
  - Stimulus: STARVE_LIMIT=4, i_req and d_req held continuously, zero-wait memory.
  - Required: grant order D,D,D,D,I,D,D,D,D,I…; starve_cnt never exceeds 4.
- Flush:
  - Stimulus: fetch granted, i_flush=1 for one cycle during WAIT, then m_rvalid with m_rdata=0x1234.
  - Required: no i_ack pulse; i_rdata still captured; FSM returns to IDLE; a new fetch to 0x200 completes normally afterwards.
- Reset mid-operation:
  - Stimulus: reset low during WAIT of a load, then release; m_rvalid arrives 1 cycle after release.
  - Required: all outputs 0 during reset; the late m_rvalid produces no ack; the next request is serviced normally.
